prog_clk_en_div: RTL and testbench

Programmable clock-enable generator. It is the parametrised successor to the fixed divide-by-256 slow-enable block. It produces a one-cycle `tick` every DIV+1 clock cycles, where DIV is loadable at run time. It supports two modes, free-running periodic and single-shot, plus a pause (`hold`). It drives game-speed, debounce and display-scan enables from the single system clock.

---
 rtl/prog_clk_en_div_if.sv | 34 +++
 rtl/prog_clk_en_div.sv | 110 +++++++++++
 tb/tb_prog_clk_en_div.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_clk_en_div_if.sv
// Control/status bundle for the programmable clock-enable divider.
// sq_out exists only when SQUARE_OUT_EN is defined.
interface prog_clk_en_div_if #(
    parameter int WIDTH = 8
);
    logic             run;
    logic             mode;
    logic             start;
    logic             hold;
    logic             div_load;
    logic [WIDTH-1:0] div_val;
    logic             tick;
    logic             busy;
    logic [WIDTH-1:0] count;
`ifdef SQUARE_OUT_EN
    logic             sq_out;
`endif

    modport master (
        output run, mode, start, hold, div_load, div_val,
`ifdef SQUARE_OUT_EN
        input  sq_out,
`endif
        input  tick, busy, count
    );

    modport slave (
        input  run, mode, start, hold, div_load, div_val,
`ifdef SQUARE_OUT_EN
        output sq_out,
`endif
        output tick, busy, count
    );
endinterface

// File: rtl/prog_clk_en_div.sv
// Programmable clock-enable: one-cycle tick every DIV+1 clocks, periodic or one-shot.
// Optional SQUARE_OUT_EN adds a registered square-wave output toggled by tick.
module prog_clk_en_div #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 255
) (
    input  logic           clk,
    input  logic           rst,
    prog_clk_en_div_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PER  = 2'd1,
        S_ONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_busy;
    logic             w_term;

    assign w_term = (r_count == r_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= WIDTH'(DEFAULT_DIV);
            r_count <= '0;
            r_tick  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tick  <= w_tick_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (bus.div_load)
                r_div <= bus.div_val;
        end
    end

    // div_load and hold both freeze the state; only counting moves it
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.div_load && !bus.hold) begin
            unique case (r_state)
                S_IDLE: begin
                    if (!bus.mode && bus.run)
                        w_state_nxt = S_PER;
                    else if (bus.mode && bus.start)
                        w_state_nxt = S_ONE;
                end
                S_PER: begin
                    if (!bus.run)
                        w_state_nxt = S_IDLE;
                end
                S_ONE: begin
                    if (w_term)
                        w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        w_tick_nxt  = 1'b0;
        if (bus.div_load) begin
            w_count_nxt = '0;
        end else if (!bus.hold) begin
            unique case (r_state)
                S_PER, S_ONE: begin
                    if (r_state == S_PER && !bus.run) begin
                        w_count_nxt = '0;
                    end else if (w_term) begin
                        w_count_nxt = '0;
                        w_tick_nxt  = 1'b1;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
                default: w_count_nxt = '0;
            endcase
        end
    end

`ifdef SQUARE_OUT_EN
    logic r_sq;

    always_ff @(posedge clk) begin
        if (rst)
            r_sq <= 1'b0;
        else if (w_state_nxt == S_IDLE)
            r_sq <= 1'b0;
        else if (w_tick_nxt)
            r_sq <= ~r_sq;
    end

    assign bus.sq_out = r_sq;
`endif

    assign bus.tick  = r_tick;
    assign bus.busy  = r_busy;
    assign bus.count = r_count;
endmodule

// File: tb/tb_prog_clk_en_div.sv
// Scoreboard bench for prog_clk_en_div: directed scenarios then random traffic.
// A cycle-level reference model pushes expectations; a negedge monitor checks them.
module tb_prog_clk_en_div;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_clk_en_div_if #(.WIDTH(W)) bus ();

    prog_clk_en_div #(.WIDTH(W), .DEFAULT_DIV(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit tick;
        bit busy;
        int count;
        bit sq;
    } exp_t;

    exp_t q[$];
    int n_vec  = 0;
    int n_fail = 0;
    int n_cyc  = 0;

    // reference model: activity 0=idle 1=periodic 2=one-shot
    int m_act  = 0;
    int m_div  = 255;
    int m_cnt  = 0;
    bit m_tick = 0;
    bit m_sq   = 0;

    bit t_rst, t_run, t_mode, t_start, t_hold, t_load;
    int t_val;

    task automatic model_step();
        if (t_rst) begin
            m_act = 0; m_cnt = 0; m_tick = 0; m_div = 255; m_sq = 0;
            return;
        end
        m_tick = 0;
        if (t_load) begin
            m_div = t_val;
            m_cnt = 0;
        end else if (t_hold) begin
            // frozen
        end else if (m_act == 0) begin
            m_cnt = 0;
            if (!t_mode && t_run) m_act = 1;
            else if (t_mode && t_start) m_act = 2;
        end else if (m_act == 1 && !t_run) begin
            m_act = 0;
            m_cnt = 0;
        end else if (m_cnt == m_div) begin
            m_cnt = 0;
            m_tick = 1;
            if (m_act == 2) m_act = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        if (m_act == 0) m_sq = 0;
        else if (m_tick) m_sq = ~m_sq;
    endtask

    task automatic cyc(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            rst          = t_rst;
            bus.run      = t_run;
            bus.mode     = t_mode;
            bus.start    = t_start;
            bus.hold     = t_hold;
            bus.div_load = t_load;
            bus.div_val  = W'(t_val);
            @(posedge clk);
            model_step();
            e.tick  = m_tick;
            e.busy  = (m_act != 0);
            e.count = m_cnt;
            e.sq    = m_sq;
            q.push_back(e);
            #1;
        end
    endtask

    task automatic idle_in();
        t_rst = 0; t_run = 0; t_mode = 0; t_start = 0;
        t_hold = 0; t_load = 0; t_val = 0;
    endtask

    task automatic load(input int v);
        t_load = 1; t_val = v;
        cyc(1);
        t_load = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            n_cyc++;
            n_vec++;
            if (bus.tick !== e.tick || bus.busy !== e.busy ||
                int'(bus.count) != e.count || $isunknown(bus.count)) begin
                n_fail++;
                $display("FAIL out cyc=%0d got tick=%b busy=%b count=%0d exp tick=%b busy=%b count=%0d",
                         n_cyc, bus.tick, bus.busy, bus.count, e.tick, e.busy, e.count);
            end
`ifdef SQUARE_OUT_EN
            n_vec++;
            if (bus.sq_out !== e.sq) begin
                n_fail++;
                $display("FAIL sq_out cyc=%0d got %b exp %b", n_cyc, bus.sq_out, e.sq);
            end
`endif
        end
    end

    initial begin
        idle_in();
        t_rst = 1;
        cyc(2);
        t_rst = 0;

        // default divisor: 256-cycle period
        t_run = 1;
        cyc(600);
        t_run = 0;
        cyc(3);

        // divisor 3, then drop run
        load(3);
        t_run = 1;
        cyc(20);
        t_run = 0;
        cyc(6);

        // one-shot with ignored restart
        load(5);
        t_mode = 1; t_start = 1;
        cyc(1);
        t_start = 0;
        cyc(2);
        t_start = 1;
        cyc(1);
        t_start = 0;
        cyc(10);
        t_mode = 0;

        // pause at count 4
        load(9);
        t_run = 1;
        cyc(5);
        t_hold = 1;
        cyc(7);
        t_hold = 0;
        cyc(15);
        t_run = 0;
        cyc(2);

        // load collides with terminal count, then div 0
        load(7);
        t_run = 1;
        cyc(8);
        load(2);
        cyc(10);
        load(0);
        cyc(6);
        t_hold = 1;
        load(4);
        cyc(3);
        t_hold = 0;
        cyc(8);
        t_run = 0;
        cyc(2);

        // reset mid-run at count 100
        load(255);
        t_run = 1;
        cyc(101);
        t_rst = 1;
        cyc(1);
        t_rst = 0;
        cyc(3);
        t_run = 0;
        cyc(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            t_rst   = ($urandom_range(0, 299) == 0);
            t_run   = ($urandom_range(0, 9) != 0);
            t_mode  = ($urandom_range(0, 3) == 0);
            t_start = ($urandom_range(0, 7) == 0);
            t_hold  = ($urandom_range(0, 9) == 0);
            t_load  = ($urandom_range(0, 39) == 0);
            t_val   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 6));
            if ($urandom_range(0, 99) < 3) t_run = 0;
            cyc(1);
        end
        idle_in();
        cyc(2);

        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
